// File: rtl/conv10_ofm_writer.sv
// Output feature-map writer for the dual conv10 MAC array: captures a lane vector,
// applies optional ReLU and drains it one word per cycle into the feature-map RAM.
module conv10_ofm_writer #(
    parameter int WOUT   = 8,
    parameter int DSP_NO = 512,
    parameter int WIDTH  = 16,
    parameter int RELU   = 1,
    parameter int AW     = $clog2(2 * WOUT * WOUT * DSP_NO)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample,
    input  logic             layer_sel,
    input  logic [WIDTH-1:0] ofm [0:DSP_NO-1],
    output logic             ram_we,
    output logic [AW-1:0]    ram_addr,
    output logic [WIDTH-1:0] ram_din,
    output logic             ram_feedback_1,
    output logic             ram_feedback_2,
    output logic             busy,
    output logic             overrun
);

    localparam int NPIX  = WOUT * WOUT;
    localparam int CH_W  = $clog2(DSP_NO);
    localparam int PIX_W = $clog2(NPIX);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(DSP_NO - 1);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NPIX - 1);

    typedef enum logic {IDLE, DRAIN} state_t;

    function automatic logic [WIDTH-1:0] relu_fn(input logic signed [WIDTH-1:0] w);
        if (RELU != 0 && w < 0) return '0;
        return w;
    endfunction

    state_t            state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [PIX_W-1:0]  pix1_q, pix1_d, pix2_q, pix2_d, pix_sel;
    logic              done1_q, done1_d, done2_q, done2_d;
    logic              lyr_q, lyr_d;
    logic              ovr_q, ovr_d;
    logic              we_q, we_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [WIDTH-1:0]  din_q, din_d;
    logic              fb1_q, fb1_d, fb2_q, fb2_d;
    logic              last, sel_done, capture;
    logic [WIDTH-1:0]  bank_q [0:DSP_NO-1];

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        lyr_d    = lyr_q;
        pix1_d   = pix1_q;
        pix2_d   = pix2_q;
        done1_d  = done1_q;
        done2_d  = done2_q;
        ovr_d    = ovr_q;
        fb1_d    = 1'b0;
        fb2_d    = 1'b0;
        we_d     = 1'b0;
        addr_d   = '0;
        din_d    = '0;
        capture  = 1'b0;
        pix_sel  = '0;
        last     = (state_q == DRAIN) && (ch_q == CH_LAST);

        if (state_q == DRAIN && !last) ch_d = ch_q + CH_W'(1);

        // Pixel bookkeeping happens on the cycle the last channel is on the port.
        if (last) begin
            state_d = IDLE;
            if (!lyr_q) begin
                if (pix1_q == PIX_LAST) begin
                    pix1_d  = '0;
                    done1_d = 1'b1;
                    fb1_d   = 1'b1;
                end else begin
                    pix1_d = pix1_q + PIX_W'(1);
                end
            end else begin
                if (pix2_q == PIX_LAST) begin
                    pix2_d  = '0;
                    done2_d = 1'b1;
                    fb2_d   = 1'b1;
                end else begin
                    pix2_d = pix2_q + PIX_W'(1);
                end
            end
        end

        // Use the post-update done flag so a back-to-back sample cannot reopen a finished layer.
        sel_done = layer_sel ? done2_d : done1_d;
        if (sample && !sel_done) begin
            if (state_q == IDLE || last) begin
                capture = 1'b1;
                state_d = DRAIN;
                lyr_d   = layer_sel;
                ch_d    = '0;
            end else begin
                ovr_d = 1'b1;
            end
        end

        if (state_d == DRAIN) begin
            pix_sel = lyr_d ? pix2_d : pix1_d;
            we_d    = 1'b1;
            addr_d  = AW'({lyr_d, pix_sel, ch_d});
            din_d   = relu_fn(capture ? ofm[0] : bank_q[ch_d]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ch_q    <= '0;
            lyr_q   <= 1'b0;
            pix1_q  <= '0;
            pix2_q  <= '0;
            done1_q <= 1'b0;
            done2_q <= 1'b0;
            ovr_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            fb1_q   <= 1'b0;
            fb2_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            lyr_q   <= lyr_d;
            pix1_q  <= pix1_d;
            pix2_q  <= pix2_d;
            done1_q <= done1_d;
            done2_q <= done2_d;
            ovr_q   <= ovr_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            fb1_q   <= fb1_d;
            fb2_q   <= fb2_d;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) bank_q <= ofm;
    end

    assign ram_we         = we_q;
    assign ram_addr       = addr_q;
    assign ram_din        = din_q;
    assign ram_feedback_1 = fb1_q;
    assign ram_feedback_2 = fb2_q;
    assign busy           = (state_q == DRAIN);
    assign overrun        = ovr_q;

endmodule
